demosaic_root_divsat: RTL and testbench

- Iterative signed-by-unsigned divider with saturation. It is the inverse of the coefficient multiplier in the demosaic datapath.
- Takes a 28-bit signed accumulated product and divides it by an 18-bit unsigned normaliser.
- Returns a 10-bit signed saturated quotient, ready to be fed back into the coefficient path.
- Uses the HLS block-level ap_ctrl handshake; one division in flight at a time.

---
 rtl/demosaic_root_divsat_pkg.sv | 17 +
 rtl/demosaic_root_divsat_sat.sv | 42 ++++
 rtl/demosaic_root_divsat.sv | 139 +++++++++++++
 tb/tb_demosaic_root_divsat.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/demosaic_root_divsat_pkg.sv
// demosaic_root_divsat_pkg: shared widths, saturation limits and FSM states for the demosaic divider.
//   DEF_DIN0_WIDTH / DEF_DIN1_WIDTH / DEF_DOUT_WIDTH : default operand and result widths
//   SAT_MAX / SAT_MIN                                : signed quotient clamp limits at the default width
//   state_t                                          : IDLE -> CALC -> DONE controller states
//   cnt_width()                                      : iteration counter width for a given dividend width
package demosaic_root_divsat_pkg;
  localparam int DEF_DIN0_WIDTH = 28;
  localparam int DEF_DIN1_WIDTH = 18;
  localparam int DEF_DOUT_WIDTH = 10;
  localparam int SAT_MAX = 2 ** (DEF_DOUT_WIDTH - 1) - 1;
  localparam int SAT_MIN = -(2 ** (DEF_DOUT_WIDTH - 1));
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
  localparam int CNT_W = cnt_width(DEF_DIN0_WIDTH);
endpackage

// File: rtl/demosaic_root_divsat_sat.sv
// demosaic_root_divsat_sat: applies sign, optional round-half-away-from-zero and signed saturation to a magnitude quotient.
//   mag_i  : unsigned magnitude quotient
//   neg_i  : result is negative (dividend sign)
//   rnd_i  : round-up request, used only when DEMOSAIC_DIVSAT_ROUND_EN is defined
//   dz_i   : divisor was zero; forces the clamp toward the dividend sign
//   dout_o : signed saturated quotient
//   ovf_o  : quotient was clamped (always set on divide by zero)
module demosaic_root_divsat_sat
  import demosaic_root_divsat_pkg::*;
#(
  parameter int MAG_WIDTH = DEF_DIN0_WIDTH,
  parameter int OUT_WIDTH = DEF_DOUT_WIDTH
) (
  input  logic [MAG_WIDTH-1:0]        mag_i,
  input  logic                        neg_i,
  input  logic                        rnd_i,
  input  logic                        dz_i,
  output logic signed [OUT_WIDTH-1:0] dout_o,
  output logic                        ovf_o
);
  localparam logic [MAG_WIDTH:0] POS_LIM = (MAG_WIDTH + 1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic [MAG_WIDTH:0] NEG_LIM = POS_LIM + 1'b1;
  localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
  logic [MAG_WIDTH:0] mag_r;
  logic [OUT_WIDTH-1:0] low;
  logic clamp;
`ifdef DEMOSAIC_DIVSAT_ROUND_EN
  assign mag_r = {1'b0, mag_i} + {{MAG_WIDTH{1'b0}}, rnd_i};
`else
  logic unused_rnd;
  assign unused_rnd = rnd_i;
  assign mag_r = {1'b0, mag_i};
`endif
  // Negative results may reach one step further than positive ones (-2^(N-1) is legal).
  assign clamp = mag_r > (neg_i ? NEG_LIM : POS_LIM);
  assign low = mag_r[OUT_WIDTH-1:0];
  always_comb begin
    ovf_o = dz_i | clamp;
    dout_o = ovf_o ? (neg_i ? OUT_MIN : OUT_MAX) : (neg_i ? -low : low);
  end
endmodule

// File: rtl/demosaic_root_divsat.sv
// demosaic_root_divsat: iterative restoring signed/unsigned divider with saturated quotient and ap_ctrl handshake.
//   ap_clk, ap_rst_n          : clock, asynchronous active-low reset
//   ap_start / ap_ready       : request / accepted this cycle (ap_start while idle)
//   ap_idle / ap_done         : controller idle / one-cycle result-valid pulse
//   din0 / din1               : signed dividend / unsigned divisor, sampled on acceptance only
//   dout / rem                : signed saturated quotient / remainder signed like the dividend
//   ovf / div_zero            : quotient clamped / divisor was zero
// Optional macro DEMOSAIC_DIVSAT_ROUND_EN: round the quotient to nearest, half away from zero.
module demosaic_root_divsat
  import demosaic_root_divsat_pkg::*;
#(
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_idle,
  output logic                         ap_done,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0]        din1,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic signed [DIN1_WIDTH:0]   rem,
  output logic                         ovf,
  output logic                         div_zero
);
  localparam int CW = cnt_width(DIN0_WIDTH);
  state_t state_q, state_d;
  logic neg_q, neg_d;
  logic [DIN0_WIDTH-1:0] dvd_q, dvd_d, quo_q, quo_d, quo_nx;
  logic [DIN1_WIDTH-1:0] dvs_q, dvs_d, pr_q, pr_d, pr_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d, sat_dout;
  logic signed [DIN1_WIDTH:0] rem_q, rem_d;
  logic ovf_q, ovf_d, dz_q, dz_d, sat_ovf;
  logic [DIN1_WIDTH:0] pr_sh, pr_sub, pr_ext;
  logic ge, dz, rnd;
  // One restoring step: shift in the next dividend bit, subtract the divisor when it fits.
  assign pr_sh = {pr_q, dvd_q[DIN0_WIDTH-1]};
  assign pr_sub = pr_sh - {1'b0, dvs_q};
  assign ge = pr_sh >= {1'b0, dvs_q};
  assign pr_nx = ge ? pr_sub[DIN1_WIDTH-1:0] : pr_sh[DIN1_WIDTH-1:0];
  assign quo_nx = {quo_q[DIN0_WIDTH-2:0], ge};
  assign pr_ext = {1'b0, pr_nx};
  assign dz = dvs_q == '0;
`ifdef DEMOSAIC_DIVSAT_ROUND_EN
  assign rnd = {1'b0, pr_nx, 1'b0} >= {2'b0, dvs_q};
`else
  assign rnd = 1'b0;
`endif
  demosaic_root_divsat_sat #(
    .MAG_WIDTH(DIN0_WIDTH),
    .OUT_WIDTH(DOUT_WIDTH)
  ) u_sat (
    .mag_i (quo_nx),
    .neg_i (neg_q),
    .rnd_i (rnd),
    .dz_i  (dz),
    .dout_o(sat_dout),
    .ovf_o (sat_ovf)
  );
  always_comb begin
    state_d = state_q;
    neg_d = neg_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    pr_d = pr_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    dout_d = dout_q;
    rem_d = rem_q;
    ovf_d = ovf_q;
    dz_d = dz_q;
    case (state_q)
      IDLE: if (ap_start) begin
        state_d = CALC;
        neg_d = din0[DIN0_WIDTH-1];
        // Unsigned magnitude keeps -2^(N-1) representable.
        dvd_d = din0[DIN0_WIDTH-1] ? DIN0_WIDTH'(-din0) : DIN0_WIDTH'(din0);
        dvs_d = din1;
        pr_d = '0;
        quo_d = '0;
        cnt_d = CW'(DIN0_WIDTH - 1);
      end
      CALC: begin
        dvd_d = {dvd_q[DIN0_WIDTH-2:0], 1'b0};
        pr_d = pr_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        // Results are captured on the last step so they are valid throughout DONE.
        if (cnt_q == '0) begin
          state_d = DONE;
          dout_d = sat_dout;
          ovf_d = sat_ovf;
          dz_d = dz;
          rem_d = dz ? '0 : (neg_q ? -pr_ext : pr_ext);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      neg_q <= 1'b0;
      dvd_q <= '0;
      dvs_q <= '0;
      pr_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      dout_q <= '0;
      rem_q <= '0;
      ovf_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q <= neg_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      pr_q <= pr_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      dout_q <= dout_d;
      rem_q <= rem_d;
      ovf_q <= ovf_d;
      dz_q <= dz_d;
    end
  end
  assign ap_idle = state_q == IDLE;
  assign ap_ready = ap_start & ap_idle;
  assign ap_done = state_q == DONE;
  assign dout = dout_q;
  assign rem = rem_q;
  assign ovf = ovf_q;
  assign div_zero = dz_q;
endmodule

// File: tb/tb_demosaic_root_divsat.sv
// tb_demosaic_root_divsat: scoreboard bench for demosaic_root_divsat against an arithmetic reference model.
module tb_demosaic_root_divsat;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic ap_start = 1'b0;
  logic ap_ready, ap_idle, ap_done, ovf, div_zero;
  logic signed [27:0] din0 = '0;
  logic [17:0] din1 = '0;
  logic signed [9:0] dout;
  logic signed [18:0] rem;

  demosaic_root_divsat dut (
    .ap_clk  (ap_clk),
    .ap_rst_n(ap_rst_n),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_idle (ap_idle),
    .ap_done (ap_done),
    .din0    (din0),
    .din1    (din1),
    .dout    (dout),
    .rem     (rem),
    .ovf     (ovf),
    .div_zero(div_zero)
  );

  initial forever #5 ap_clk = ~ap_clk;

  typedef struct {
    longint dout;
    longint rem;
    bit     ovf;
    bit     dz;
    longint cyc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  int dones = 0;
  longint cyc = 0;
  longint prev_acc = -1;
  bit prev_hold = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // C-style truncating division, optional half-away rounding, then clamp to [-512, 511].
  function automatic exp_t model(input longint a, input longint b);
    exp_t e;
    longint q, r, ar;
    e.cyc = 0;
    if (b == 0) begin
      e.dz = 1;
      e.ovf = 1;
      e.dout = (a < 0) ? -512 : 511;
      e.rem = 0;
      return e;
    end
    e.dz = 0;
    q = a / b;
    r = a % b;
    ar = (r < 0) ? -r : r;
`ifdef DEMOSAIC_DIVSAT_ROUND_EN
    if (2 * ar >= b) q = (a < 0) ? q - 1 : q + 1;
`endif
    e.ovf = (q > 511) || (q < -512);
    e.dout = (q > 511) ? 511 : (q < -512) ? -512 : q;
    e.rem = r;
    return e;
  endfunction

  always @(negedge ap_clk) begin
    if (ap_rst_n && ap_done) begin
      exp_t e;
      dones++;
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("dout", longint'(dout), e.dout);
        chk("rem", longint'(rem), e.rem);
        chk("ovf", longint'(ovf), longint'(e.ovf));
        chk("div_zero", longint'(div_zero), longint'(e.dz));
        chk("latency", cyc, e.cyc + 29);
      end
    end
  end

  task automatic issue(input longint a, input longint b, input bit hold, input bit track);
    int n = 0;
    exp_t e;
    @(negedge ap_clk);
    din0 = 28'(a);
    din1 = 18'(b);
    ap_start = 1'b1;
    #1;
    while (!ap_ready && n < 100) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    if (!ap_ready) begin
      chk("accept_timeout", 0, 1);
      ap_start = 1'b0;
      return;
    end
    if (prev_hold) chk("back_to_back_period", cyc - prev_acc, 30);
    prev_acc = cyc;
    prev_hold = hold;
    if (track) begin
      e = model(a, b);
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge ap_clk);
    #1;
    chk("ready_after_accept", longint'(ap_ready), 0);
    chk("idle_after_accept", longint'(ap_idle), 0);
    if (!hold) ap_start = 1'b0;
    din0 = 28'($urandom);
    din1 = 18'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  longint dir_a[11] = '{1000, -1000, -1536, 1536, 134217727, -134217728, 5, -5, 0, 7, 1533};
  longint dir_b[11] = '{7, 7, 3, 3, 1, 1, 0, 0, 0, 2, 3};

  initial begin
    int d0;
    repeat (3) @(negedge ap_clk);
    #1;
    chk("rst_idle", longint'(ap_idle), 1);
    chk("rst_done", longint'(ap_done), 0);
    chk("rst_ready", longint'(ap_ready), 0);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_rem", longint'(rem), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_div_zero", longint'(div_zero), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    foreach (dir_a[i]) issue(dir_a[i], dir_b[i], 1'b0, 1'b1);
    drain();

    // Abandon an operation partway through the iteration.
    d0 = dones;
    issue(1000, 7, 1'b0, 1'b0);
    repeat (9) @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("midrst_idle", longint'(ap_idle), 1);
    chk("midrst_dout", longint'(dout), 0);
    chk("midrst_rem", longint'(rem), 0);
    chk("midrst_done", longint'(ap_done), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (40) @(negedge ap_clk);
    chk("midrst_no_done", dones - d0, 0);
    chk("midrst_idle_after", longint'(ap_idle), 1);
    prev_hold = 0;
    issue(100, 10, 1'b0, 1'b1);
    drain();

    for (int k = 0; k < 300; k++) begin
      logic signed [27:0] t;
      longint a, b;
      bit hold;
      t = 28'($urandom);
      a = ($urandom_range(0, 1) == 0) ? longint'(t) : longint'($urandom_range(0, 8000)) - 4000;
      case ($urandom_range(0, 7))
        0: b = 0;
        1, 2, 3: b = $urandom_range(1, 20);
        default: b = $urandom_range(1, 262143);
      endcase
      hold = (k != 299) && ($urandom_range(0, 3) == 0);
      if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge ap_clk);
      issue(a, b, hold, 1'b1);
    end
    ap_start = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
